// File: rtl/seq_mul_pkg.sv
// Shared types and elaboration helpers for the iterative multiplier seq_mul.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int iter_count(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter must be able to hold N itself, not just N-1.
  function automatic int cnt_width(input int width, input int digit);
    return $clog2(iter_count(width, digit) + 1);
  endfunction

  function automatic bit params_legal(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/seq_mul_digit.sv
// Combinational WIDTH x DIGIT unsigned multiply-accumulate: acc_hi + a*digit.
module seq_mul_digit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [DIGIT-1:0]       digit,
  input  logic [WIDTH-1:0]       acc_hi,
  output logic [WIDTH+DIGIT-1:0] sum
);

  localparam int SW = WIDTH + DIGIT;

  logic [SW-1:0] a_ext_s;
  logic [SW-1:0] d_ext_s;
  logic [SW-1:0] hi_ext_s;

  // (2^W-1) + (2^W-1)(2^D-1) < 2^(W+D), so the sum never overflows SW bits.
  assign a_ext_s  = SW'(a);
  assign d_ext_s  = SW'(digit);
  assign hi_ext_s = SW'(acc_hi);
  assign sum      = hi_ext_s + a_ext_s * d_ext_s;

endmodule

// File: rtl/seq_mul.sv
// Iterative signed/unsigned multiplier retiring DIGIT multiplier bits per cycle,
// with valid/ready handshakes on operands and result.
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  localparam int N  = iter_count(WIDTH, DIGIT);
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0]      LAST   = CW'(N - 1);
  localparam logic [CW-1:0]      ONE_CW = CW'(1'b1);
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1'b1);
  localparam logic [2*WIDTH-1:0] ONE_P  = (2 * WIDTH)'(1'b1);

  if (!params_legal(WIDTH, DIGIT)) begin : g_param_check
    $error("seq_mul: illegal WIDTH/DIGIT combination");
  end

  state_e               state_r;
  state_e               state_s;
  logic [WIDTH-1:0]     mag_a_r;
  logic [2*WIDTH-1:0]   prod_r;
  logic [2*WIDTH-1:0]   prod_next_s;
  logic [2*WIDTH-1:0]   out_p_r;
  logic                 neg_r;
  logic [CW-1:0]        cnt_r;
  logic [WIDTH-1:0]     mag_a_s;
  logic [WIDTH-1:0]     mag_b_s;
  logic                 sign_s;
  logic                 last_s;
  logic [WIDTH+DIGIT-1:0] sum_s;

  // Operand magnitudes and result sign; |min| = 2^(W-1) still fits unsigned.
  always_comb begin
    mag_a_s = in_a;
    mag_b_s = in_b;
    sign_s  = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
    if (in_signed && in_a[WIDTH-1]) begin
      mag_a_s = ~in_a + ONE_W;
    end else begin
      mag_a_s = in_a;
    end
    if (in_signed && in_b[WIDTH-1]) begin
      mag_b_s = ~in_b + ONE_W;
    end else begin
      mag_b_s = in_b;
    end
  end

  // prod_r holds {accumulator upper half, unretired multiplier bits}.
  seq_mul_digit #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_digit (
    .a      (mag_a_r),
    .digit  (prod_r[DIGIT-1:0]),
    .acc_hi (prod_r[2*WIDTH-1:WIDTH]),
    .sum    (sum_s)
  );

  if (DIGIT == WIDTH) begin : g_full
    assign prod_next_s = sum_s;
  end else begin : g_part
    assign prod_next_s = {sum_s, prod_r[WIDTH-1:DIGIT]};
  end

  assign last_s = (cnt_r == LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_s   = state_r;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_s = CALC;
        else          state_s = IDLE;
      end
      CALC: begin
        if (last_s) state_s = DONE;
        else        state_s = CALC;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add iterations and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_a_r <= {WIDTH{1'b0}};
      prod_r  <= {(2 * WIDTH){1'b0}};
      out_p_r <= {(2 * WIDTH){1'b0}};
      neg_r   <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            mag_a_r <= mag_a_s;
            prod_r  <= {{WIDTH{1'b0}}, mag_b_s};
            neg_r   <= sign_s;
            cnt_r   <= {CW{1'b0}};
          end
        end
        CALC: begin
          prod_r <= prod_next_s;
          cnt_r  <= cnt_r + ONE_CW;
          // Negating a zero magnitude yields zero, so no -0 can appear.
          if (last_s) begin
            out_p_r <= neg_r ? (~prod_next_s + ONE_P) : prod_next_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_p = out_p_r;

endmodule
